// File: rtl/axil_wr_arb.sv
// rtl/axil_wr_arb.sv - two-master round-robin AXI-lite write-channel arbiter
// One transaction outstanding; AW/W forwarded together, B routed back to the granted master.
module axil_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [1:0]              s_awvalid,
    output logic [1:0]              s_awready,
    input  logic [2*DATA_WIDTH-1:0] s_wdata,
    input  logic [2*STRB_WIDTH-1:0] s_wstrb,
    input  logic [1:0]              s_wvalid,
    output logic [1:0]              s_wready,
    output logic [3:0]              s_bresp,
    output logic [1:0]              s_bvalid,
    input  logic [1:0]              s_bready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [STRB_WIDTH-1:0]   m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       g, g_nxt;
    logic       last_grant, last_grant_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;
    logic       aw_hs, w_hs;
    logic [1:0] req;

    // A master is eligible only when it presents both AW and W.
    assign req = s_awvalid & s_wvalid;

    assign m_awaddr = g ? s_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_awaddr[ADDR_WIDTH-1:0];
    assign m_wdata  = g ? s_wdata[2*DATA_WIDTH-1:DATA_WIDTH]  : s_wdata[DATA_WIDTH-1:0];
    assign m_wstrb  = g ? s_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]  : s_wstrb[STRB_WIDTH-1:0];
    assign s_bresp  = {2{m_bresp}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            g          <= g_nxt;
            last_grant <= last_grant_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        g_nxt          = g;
        last_grant_nxt = last_grant;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        m_awvalid      = 1'b0;
        m_wvalid       = 1'b0;
        m_bready       = 1'b0;
        s_awready      = 2'b00;
        s_wready       = 2'b00;
        s_bvalid       = 2'b00;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    g_nxt     = (req == 2'b11) ? ~last_grant : req[1];
                    state_nxt = XFER;
                end
            end
            XFER: begin
                m_awvalid    = s_awvalid[g] & ~aw_done;
                m_wvalid     = s_wvalid[g] & ~w_done;
                s_awready[g] = m_awready & ~aw_done;
                s_wready[g]  = m_wready & ~w_done;
                aw_hs        = m_awvalid & m_awready;
                w_hs         = m_wvalid & m_wready;
                // AW and W may complete in either order or together.
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    state_nxt   = RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            RESP: begin
                s_bvalid[g] = m_bvalid;
                m_bready    = s_bready[g];
                if (m_bvalid & m_bready) begin
                    last_grant_nxt = g;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_wr_arb.sv
// tb/tb_axil_wr_arb.sv - randomized self-checking bench for axil_wr_arb
module tb_axil_wr_arb;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic            clk;
    logic            rst;
    logic [2*AW-1:0] s_awaddr;
    logic [1:0]      s_awvalid, s_awready;
    logic [2*DW-1:0] s_wdata;
    logic [2*SW-1:0] s_wstrb;
    logic [1:0]      s_wvalid, s_wready;
    logic [3:0]      s_bresp;
    logic [1:0]      s_bvalid, s_bready;
    logic [AW-1:0]   m_awaddr;
    logic            m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready;

    axil_wr_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // stimulus knobs
    int mode, bready_pct, ardy_pct, wrdy_pct, b_dly_max, aw_dly_cfg, bresp_fix;
    int gap_aw[2], gap_w[2], w_min[2];
    // master models
    bit          act[2], aw_sent[2], w_sent[2];
    int          aw_wait[2], w_wait[2], left[2];
    logic [31:0] c_addr[2], c_data[2];
    logic [3:0]  c_strb[2];
    // slave model
    bit          sl_aw, sl_w, b_pend;
    int          aw_dly, b_dly;
    logic [1:0]  b_resp;
    // handshakes seen in the cycle just sampled
    bit          h_saw[2], h_sw[2], h_sb[2];
    bit          h_maw, h_mw, h_mb;
    // reference: one transaction in flight, round-robin on ties
    bit          busy, last, win, exp_lat, mdl_aw, mdl_w;
    int          ntx, cyc, last_b_cyc, bv_cnt[2];
    bit          chk_gap;
    logic [31:0] got_q[$];

    task automatic clear_all();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; aw_sent[i] = 0; w_sent[i] = 0; aw_wait[i] = 0; w_wait[i] = 0;
            h_saw[i] = 0; h_sw[i] = 0; h_sb[i] = 0;
        end
        h_maw = 0; h_mw = 0; h_mb = 0;
        sl_aw = 0; sl_w = 0; b_pend = 0; b_dly = 0; b_resp = 2'b00; aw_dly = aw_dly_cfg;
        busy = 0; last = 1; win = 0; exp_lat = 0; mdl_aw = 0; mdl_w = 0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk); #1;
        rst = 1;
        clear_all();
        repeat (ncyc) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_out", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}, 0);
    endtask

    task automatic model();
        logic [1:0] req;
        bit was_busy;
        req = s_awvalid & s_wvalid;
        was_busy = busy;
        if (exp_lat) begin
            check("lat_awvalid", m_awvalid, 1);
            check("lat_wvalid", m_wvalid, 1);
            exp_lat = 0;
        end
        if (!was_busy) begin
            check("idle_out", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
        end else begin
            check("other_quiet", {s_awready[!win], s_wready[!win], s_bvalid[!win]}, 0);
            if (mdl_aw) check("aw_after_done", m_awvalid, 0);
            if (mdl_w) check("w_after_done", m_wvalid, 0);
            if (h_maw) begin
                check("awaddr", m_awaddr, c_addr[win]);
                check("aw_single", sl_aw | b_pend, 0);
                mdl_aw = 1;
            end
            if (h_mw) begin
                check("wdata", m_wdata, c_data[win]);
                check("wstrb", m_wstrb, c_strb[win]);
                got_q.push_back(m_wdata);
                mdl_w = 1;
            end
            if (m_bvalid) begin
                check("bvalid_route", s_bvalid[win], 1);
                check("bresp_route", s_bresp[2*int'(win) +: 2], b_resp);
                check("bready_route", m_bready, s_bready[win]);
            end
            if (h_mb) begin
                busy = 0; last = win; mdl_aw = 0; mdl_w = 0; ntx++;
                if (chk_gap && last_b_cyc >= 0) check("b_gap", cyc - last_b_cyc, 3);
                last_b_cyc = cyc;
            end
        end
        if (!was_busy && req != 2'b00) begin
            win = (req == 2'b11) ? !last : req[1];
            busy = 1;
            exp_lat = 1;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (h_saw[i]) aw_sent[i] = 1;
            if (h_sw[i]) w_sent[i] = 1;
            if (h_sb[i]) act[i] = 0;
        end
        if (h_maw) sl_aw = 1;
        if (h_mw) sl_w = 1;
        if (h_mb) begin b_pend = 0; aw_dly = aw_dly_cfg; end
        if (sl_aw && sl_w) begin
            sl_aw = 0; sl_w = 0; b_pend = 1;
            b_dly = $urandom_range(0, b_dly_max);
            b_resp = (bresp_fix >= 0) ? 2'(bresp_fix) : 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < 2; i++) begin
            if (!act[i] && left[i] > 0) begin
                act[i] = 1; aw_sent[i] = 0; w_sent[i] = 0; left[i]--;
                aw_wait[i] = $urandom_range(0, gap_aw[i]);
                w_wait[i] = w_min[i] + $urandom_range(0, gap_w[i]);
                if (mode == 1) begin
                    c_addr[i] = 32'h1000_0000; c_data[i] = 32'hDEAD_BEEF; c_strb[i] = 4'hF;
                end else if (mode == 2) begin
                    c_addr[i] = $urandom; c_data[i] = 32'(i + 1); c_strb[i] = 4'hF;
                end else begin
                    c_addr[i] = $urandom; c_data[i] = $urandom; c_strb[i] = 4'($urandom_range(0, 15));
                end
            end
            s_awvalid[i] = act[i] && !aw_sent[i] && aw_wait[i] == 0;
            s_wvalid[i]  = act[i] && !w_sent[i] && w_wait[i] == 0;
            if (act[i] && aw_wait[i] > 0) aw_wait[i]--;
            if (act[i] && w_wait[i] > 0) w_wait[i]--;
            s_awaddr[i*AW +: AW] = c_addr[i];
            s_wdata[i*DW +: DW]  = c_data[i];
            s_wstrb[i*SW +: SW]  = c_strb[i];
            s_bready[i] = ($urandom_range(0, 99) < bready_pct);
        end
        m_awready = (aw_dly == 0) && ($urandom_range(0, 99) < ardy_pct);
        if (aw_dly > 0) aw_dly--;
        m_wready = ($urandom_range(0, 99) < wrdy_pct);
        m_bvalid = b_pend && b_dly == 0;
        if (b_pend && b_dly > 0) b_dly--;
        m_bresp = b_resp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            h_saw[i] = s_awvalid[i] & s_awready[i];
            h_sw[i]  = s_wvalid[i] & s_wready[i];
            h_sb[i]  = s_bvalid[i] & s_bready[i];
            bv_cnt[i] += int'(s_bvalid[i]);
        end
        h_maw = m_awvalid & m_awready;
        h_mw  = m_wvalid & m_wready;
        h_mb  = m_bvalid & m_bready;
        model();
    endtask

    task automatic run_phase(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = left[0] == 0 && left[1] == 0 && !act[0] && !act[1] && !busy && !b_pend;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic setup(input int md, input int l0, input int l1, input int gap,
                         input int rpct, input int bpct, input int bdly, input int awd);
        mode = md; left[0] = l0; left[1] = l1;
        for (int i = 0; i < 2; i++) begin
            gap_aw[i] = gap; gap_w[i] = gap; w_min[i] = 0; bv_cnt[i] = 0;
        end
        ardy_pct = rpct; wrdy_pct = rpct; bready_pct = bpct; b_dly_max = bdly;
        aw_dly_cfg = awd; aw_dly = awd; bresp_fix = -1; chk_gap = 0; last_b_cyc = -1;
        got_q.delete();
        ntx = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1;
        cyc = 0;
        setup(0, 0, 0, 0, 100, 100, 0, 0);
        clear_all();
        do_reset(3);

        // lone master, zero-wait slave
        setup(1, 1, 0, 0, 100, 100, 0, 0);
        bresp_fix = 0;
        run_phase("p1", 50);
        check("p1_ntx", ntx, 1);
        check("p1_bv0", bv_cnt[0], 1);
        check("p1_bv1", bv_cnt[1], 0);
        check("p1_writes", got_q.size(), 1);

        // both continuously requesting from reset: strict alternation, 3 cycles each
        do_reset(1);
        setup(2, 4, 4, 0, 100, 100, 0, 0);
        chk_gap = 1;
        run_phase("p2", 100);
        check("p2_writes", got_q.size(), 8);
        for (int k = 0; k < got_q.size(); k++)
            check($sformatf("p2_order%0d", k), got_q[k], 64'(k % 2 + 1));

        // late awready, immediate wready
        setup(0, 3, 0, 0, 100, 100, 0, 5);
        run_phase("p3", 100);
        check("p3_ntx", ntx, 3);

        // error response held by a stalling master
        setup(0, 0, 3, 0, 100, 20, 2, 0);
        bresp_fix = 2;
        run_phase("p4", 300);
        check("p4_ntx", ntx, 3);

        // master 1 shows AW only for a while; master 0 keeps winning
        setup(2, 4, 1, 0, 100, 100, 0, 0);
        w_min[1] = 25;
        run_phase("p5", 200);
        check("p5_writes", got_q.size(), 5);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            check($sformatf("p5_m0_%0d", k), got_q[k], 1);
        if (got_q.size() == 5) check("p5_m1_last", got_q[4], 2);

        // random traffic on every channel
        setup(0, 20, 20, 3, 60, 60, 3, 0);
        run_phase("p6", 3000);
        check("p6_ntx", ntx, 40);

        // reset while a response is pending, then a tie
        setup(0, 5, 5, 2, 80, 30, 3, 0);
        n = 0;
        while (!(busy && b_pend) && n < 300) begin
            step();
            n++;
        end
        check("p7_in_resp", busy && b_pend, 1);
        do_reset(1);
        setup(2, 1, 1, 0, 100, 100, 0, 0);
        run_phase("p7", 50);
        check("p7_writes", got_q.size(), 2);
        if (got_q.size() > 0) check("p7_tie_m0", got_q[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axil_wr_arb.md
Name: axil_wr_arb

Overview:
Two-master AXI-lite write-channel arbiter that shares one write-only AXI-lite slave, the MEM_BASE FIFO slave, between requesters such as the core store path and a DMA/debug port. It is round-robin, keeps one transaction outstanding, and routes the B response back to the granted master. AR/R channels are out of scope.

Parameters:
DATA_WIDTH, 32, data width of each W channel.
ADDR_WIDTH, 32, width of each AW address.
STRB_WIDTH, DATA_WIDTH/8, width of each write strobe.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_awaddr  in  2*ADDR_WIDTH  master AW addresses; slice i = master i
s_awvalid  in  2  master AW valid
s_awready  out  2  master AW ready
s_wdata  in  2*DATA_WIDTH  master write data
s_wstrb  in  2*STRB_WIDTH  master write strobes
s_wvalid  in  2  master W valid
s_wready  out  2  master W ready
s_bresp  out  4  master B response; slice i = bits [2i+1:2i]
s_bvalid  out  2  master B valid
s_bready  in  2  master B ready
m_awaddr  out  ADDR_WIDTH  slave AW address
m_awvalid  out  1  slave AW valid
m_awready  in  1  slave AW ready
m_wdata  out  DATA_WIDTH  slave write data
m_wstrb  out  STRB_WIDTH  slave strobes
m_wvalid  out  1  slave W valid
m_wready  in  1  slave W ready
m_bresp  in  2  slave B response
m_bvalid  in  1  slave B valid
m_bready  out  1  slave B ready

Behaviour:
- Registered state: FSM {IDLE, XFER, RESP}, grant g (1 bit), last_grant (1 bit), aw_done, w_done.
- Reset (rst=1 at a clock edge): state=IDLE, g=0, last_grant=1 so master 0 wins the first tie, aw_done=w_done=0. All s_*ready, s_bvalid, m_awvalid, m_wvalid and m_bready are 0 from the cycle after the reset edge.
- Reset mid-transaction aborts the transaction immediately with no B response to the master. The bench must reset the slave together with the arbiter.
- Request: req[i] = s_awvalid[i] & s_wvalid[i]. A master presenting AW only, or W only, is not eligible.
- IDLE: all m_* valids = 0 and all s_* readies = 0.
  - If any req is set, g <= the requester; if both are set, g <= ~last_grant. state <= XFER.
  - Arbitration latency is 1 cycle: a request sampled in cycle N gives m_awvalid/m_wvalid = 1 in cycle N+1.
- XFER: m_awaddr/m_wdata/m_wstrb = slice g, driven combinationally.
  - m_awvalid = s_awvalid[g] & ~aw_done; m_wvalid = s_wvalid[g] & ~w_done.
  - s_awready[g] = m_awready & ~aw_done; s_wready[g] = m_wready & ~w_done.
  - AW and W are presented in the same cycle so a slave whose awready depends on wvalid cannot deadlock.
  - aw_done sets on an AW handshake; w_done sets on a W handshake.
  - When both are done (handshakes may fall in the same cycle or in different cycles): state <= RESP and both flags clear.
- RESP: s_bvalid[g] = m_bvalid; all s_bresp slices = m_bresp; m_bready = s_bready[g].
  - On m_bvalid & m_bready: last_grant <= g, state <= IDLE.
- Non-granted master: s_awready, s_wready and s_bvalid stay 0 in every state. Its valids must stay held per AXI rules; the arbiter never drops a held request.
- m_* data outputs in IDLE/RESP: hold slice g; the value is don't-care.
- Throughput: a zero-wait slave that asserts bvalid the cycle after the W handshake gives 1 transaction per 3 cycles (IDLE, XFER, RESP).
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- No timeout. A slave that never responds hangs the arbiter in RESP until reset.
- Masters must not change AW/W payload while valid is high (AXI rule).

Test Plan:
1. Master 0 alone: awaddr=0x10000000, wdata=0xDEADBEEF, wstrb=0xF, zero-wait slave, bresp=0 -> slave sees exactly one AW+W with those values 1 cycle after the request; s_bvalid[0]=1 for one cycle; s_bvalid[1] never asserts.
2. Both masters request together from reset (m0 data=0x1, m1 data=0x2), 4 transactions each -> slave data order is 1,2,1,2,...; each B response is routed to the master that issued that transaction.
3. Slave awready delayed 3 cycles while wready is immediate -> W accepted first, m_wvalid drops after its handshake, AW completes later; exactly one write reaches the slave and the FSM enters RESP only after both handshakes.
4. Slave returns bresp=2'b10 and holds bvalid while s_bready[1]=0 for 5 cycles -> s_bresp[3:2]=2'b10 is held stable; no new grant is issued until the handshake; IDLE follows on the cycle after it.
5. Master 1 asserts only awvalid (no wvalid) while master 0 requests fully -> master 0 is granted repeatedly; master 1 is granted once its wvalid rises.
6. Assert rst for 1 cycle during RESP -> all outputs are 0 on the next cycle; the next tie goes to master 0.
